// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: payload+valid, stall-vector bubble/hold/flush,
// multicycle context loop-back, saturating stall counter, sticky illegal-stall flag.
module pipe_stage_reg #(
  parameter int                  DATA_W       = 64,
  parameter int                  CTX_W        = 66,
  parameter int                  STALL_W      = 6,
  parameter int                  UP_IDX       = 3,
  parameter logic [DATA_W-1:0]   NOP_VAL      = '0,
  parameter bit                  GATE_INVALID = 1'b1,
  parameter int                  CNT_W        = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [CTX_W-1:0]   ctx_i,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  output logic [CTX_W-1:0]   ctx_o,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic               err_stall
);

  generate
    if (UP_IDX + 1 >= STALL_W) begin : g_bad_idx
      $error("pipe_stage_reg: UP_IDX+1 must be below STALL_W");
    end
  endgenerate

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic up, dn;
  logic [CNT_W-1:0]  cnt_inc;
  logic [DATA_W-1:0] adv_data;

  assign up      = stall[UP_IDX];
  assign dn      = stall[UP_IDX+1];
  assign cnt_inc = (stall_cnt == CNT_MAX) ? stall_cnt : stall_cnt + 1'b1;
  // Invalid slots only carry in_data through when gating is disabled.
  assign adv_data = (in_valid || !GATE_INVALID) ? in_data : NOP_VAL;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= NOP_VAL;
      ctx_o     <= '0;
      stall_cnt <= '0;
      err_stall <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_data  <= NOP_VAL;
      ctx_o     <= '0;
      stall_cnt <= '0;
    end else begin
      case ({up, dn})
        2'b10: begin
          out_valid <= 1'b0;
          out_data  <= NOP_VAL;
          ctx_o     <= ctx_i;
          stall_cnt <= cnt_inc;
        end
        2'b00: begin
          out_valid <= in_valid;
          out_data  <= adv_data;
          ctx_o     <= '0;
          stall_cnt <= '0;
        end
        2'b11: begin
          ctx_o     <= ctx_i;
          stall_cnt <= cnt_inc;
        end
        default: begin
          // Downstream stopped while upstream runs: keep the held payload intact.
          ctx_o     <= '0;
          stall_cnt <= '0;
          err_stall <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed table-driven bench for pipe_stage_reg plus hand sequences for
// saturation, async reset mid-hold and the ungated / non-zero NOP variant.
module tb_pipe_stage_reg;

  localparam logic [65:0] C5 = 66'h1_0000_0000_0000_0005;
  localparam logic [65:0] C7 = 66'h2_0000_0000_0000_0007;
  localparam logic [63:0] NOP2 = 64'hDEAD;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic        in_valid;
  logic [63:0] in_data;
  logic [65:0] ctx_i;

  logic        out_valid, out_valid2;
  logic [63:0] out_data, out_data2;
  logic [65:0] ctx_o, ctx_o2;
  logic [3:0]  stall_cnt, stall_cnt2;
  logic        err_stall, err_stall2;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  pipe_stage_reg u_dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_data(in_data), .ctx_i(ctx_i), .out_valid(out_valid), .out_data(out_data),
    .ctx_o(ctx_o), .stall_cnt(stall_cnt), .err_stall(err_stall)
  );

  pipe_stage_reg #(.NOP_VAL(NOP2), .GATE_INVALID(1'b0)) u_nog (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_data(in_data), .ctx_i(ctx_i), .out_valid(out_valid2), .out_data(out_data2),
    .ctx_o(ctx_o2), .stall_cnt(stall_cnt2), .err_stall(err_stall2)
  );

  typedef struct {
    logic [5:0]  stall;
    logic        flush;
    logic        iv;
    logic [63:0] d;
    logic [65:0] ctx;
    logic        ev;
    logic [63:0] ed;
    logic [65:0] ectx;
    logic [3:0]  ecnt;
    logic        eerr;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic ev, input logic [63:0] ed,
                         input logic [65:0] ectx, input logic [3:0] ecnt, input logic eerr);
    chk({tag, ".valid"}, 128'(out_valid), 128'(ev));
    chk({tag, ".data"},  128'(out_data),  128'(ed));
    chk({tag, ".ctx"},   128'(ctx_o),     128'(ectx));
    chk({tag, ".cnt"},   128'(stall_cnt), 128'(ecnt));
    chk({tag, ".err"},   128'(err_stall), 128'(eerr));
  endtask

  task automatic drive(input logic [5:0] s, input logic f, input logic iv,
                       input logic [63:0] d, input logic [65:0] c);
    stall = s; flush = f; in_valid = iv; in_data = d; ctx_i = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0]  = '{6'b000000, 1'b0, 1'b1, 64'h1,  66'h0, 1'b1, 64'h1,  66'h0, 4'd0, 1'b0};
    tbl[1]  = '{6'b000000, 1'b0, 1'b1, 64'h2,  66'h0, 1'b1, 64'h2,  66'h0, 4'd0, 1'b0};
    tbl[2]  = '{6'b000000, 1'b0, 1'b1, 64'h3,  66'h0, 1'b1, 64'h3,  66'h0, 4'd0, 1'b0};
    tbl[3]  = '{6'b000000, 1'b0, 1'b0, 64'h55, 66'h0, 1'b0, 64'h0,  66'h0, 4'd0, 1'b0};
    tbl[4]  = '{6'b000000, 1'b0, 1'b1, 64'h10, 66'h0, 1'b1, 64'h10, 66'h0, 4'd0, 1'b0};
    tbl[5]  = '{6'b001111, 1'b0, 1'b1, 64'h11, C5,    1'b0, 64'h0,  C5,    4'd1, 1'b0};
    tbl[6]  = '{6'b001111, 1'b0, 1'b1, 64'h11, C5,    1'b0, 64'h0,  C5,    4'd2, 1'b0};
    tbl[7]  = '{6'b000000, 1'b0, 1'b1, 64'h20, C5,    1'b1, 64'h20, 66'h0, 4'd0, 1'b0};
    tbl[8]  = '{6'b011000, 1'b0, 1'b1, 64'h21, C7,    1'b1, 64'h20, C7,    4'd1, 1'b0};
    tbl[9]  = '{6'b011000, 1'b0, 1'b1, 64'h21, C7,    1'b1, 64'h20, C7,    4'd2, 1'b0};
    tbl[10] = '{6'b100111, 1'b0, 1'b1, 64'h33, C7,    1'b1, 64'h33, 66'h0, 4'd0, 1'b0};
    tbl[11] = '{6'b001111, 1'b1, 1'b1, 64'h44, C7,    1'b0, 64'h0,  66'h0, 4'd0, 1'b0};
    tbl[12] = '{6'b000000, 1'b0, 1'b1, 64'hAA, 66'h0, 1'b1, 64'hAA, 66'h0, 4'd0, 1'b0};
    tbl[13] = '{6'b010000, 1'b0, 1'b1, 64'hBB, C7,    1'b1, 64'hAA, 66'h0, 4'd0, 1'b1};
    tbl[14] = '{6'b000000, 1'b0, 1'b1, 64'hCC, 66'h0, 1'b1, 64'hCC, 66'h0, 4'd0, 1'b1};
    tbl[15] = '{6'b000000, 1'b1, 1'b1, 64'hDD, 66'h0, 1'b0, 64'h0,  66'h0, 4'd0, 1'b1};

    rst = 1'b0; stall = '0; flush = 1'b0; in_valid = 1'b0; in_data = '0; ctx_i = '0;
    #12;
    chk_all("reset", 1'b0, 64'h0, 66'h0, 4'd0, 1'b0);
    chk("reset.nop2", 128'(out_data2), 128'(NOP2));
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].stall, tbl[i].flush, tbl[i].iv, tbl[i].d, tbl[i].ctx);
      chk_all($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ed, tbl[i].ectx, tbl[i].ecnt, tbl[i].eerr);
    end

    // Saturation: 20 holds after loading 0x77
    drive(6'b000000, 1'b0, 1'b1, 64'h77, 66'h0);
    for (int i = 0; i < 20; i++) begin
      drive(6'b011000, 1'b0, 1'b1, 64'h88, C5);
      chk($sformatf("sat%0d.cnt", i), 128'(stall_cnt), 128'((i + 1 > 15) ? 15 : i + 1));
      chk($sformatf("sat%0d.data", i), 128'(out_data), 128'(64'h77));
    end

    // Async reset in the middle of a hold
    drive(6'b000000, 1'b0, 1'b1, 64'h99, 66'h0);
    for (int i = 0; i < 3; i++) drive(6'b011000, 1'b0, 1'b1, 64'h9A, C7);
    chk("prehold.cnt", 128'(stall_cnt), 128'(4'd3));
    #2 rst = 1'b0;
    #1;
    chk_all("midrst", 1'b0, 64'h0, 66'h0, 4'd0, 1'b0);
    chk("midrst.nop2", 128'(out_data2), 128'(NOP2));
    stall = '0;
    #2 rst = 1'b1;
    @(negedge clk);

    // Ungated instance passes in_data on invalid advance; bubble uses its NOP
    drive(6'b000000, 1'b0, 1'b0, 64'h55, 66'h0);
    chk("nog.data", 128'(out_data2), 128'(64'h55));
    chk("nog.valid", 128'(out_valid2), 128'(1'b0));
    chk("gate.data", 128'(out_data), 128'(64'h0));
    drive(6'b001111, 1'b0, 1'b1, 64'h66, C5);
    chk("nog.bubble", 128'(out_data2), 128'(NOP2));
    chk("nog.ctx", 128'(ctx_o2), 128'(C5));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised inter-stage pipeline register, one instance per stage boundary (if/id, id/ex, ex/mem, mem/wb).
- Carries an opaque payload with a valid bit.
- Applies the team's stall-vector semantics, inserts bubbles and honours flush.
- Loops multicycle execution context (e.g. partial HI/LO product and cycle count) back to the producing stage while that stage is stalled.
- New over fixed per-stage registers:
  - configurable NOP pattern;
  - invalid-input gating;
  - saturating stall-cycle counter;
  - protection and sticky error flag for an illegal stall combination.

Parameters:
- DATA_W, 64: payload width in bits.
- CTX_W, 66: multicycle context width (64-bit partial product plus 2-bit cycle count).
- STALL_W, 6: width of the controller stall vector.
- UP_IDX, 3: stall bit of the producing stage. The consuming stage uses bit UP_IDX+1.
- NOP_VAL, 0: payload pattern driven for reset, flush and bubble.
- GATE_INVALID, 1: when 1, an advance with in_valid=0 loads NOP_VAL instead of in_data.
- CNT_W, 4: stall counter width.

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: asynchronous reset, active-low.
- stall, input, STALL_W: controller stall vector. Stop=1, NoStop=0.
- flush, input, 1: pipeline flush (exception/eret).
- in_valid, input, 1: producing stage holds a real instruction.
- in_data, input, DATA_W: producing-stage payload.
- ctx_i, input, CTX_W: multicycle context from the producing stage.
- out_valid, output, 1: registered valid to the consuming stage.
- out_data, output, DATA_W: registered payload.
- ctx_o, output, CTX_W: context returned to the producing stage.
- stall_cnt, output, CNT_W: consecutive cycles the producing stage has been stalled. Saturates.
- err_stall, output, 1: sticky flag for the illegal combination "up NoStop, down Stop".

Behaviour:
- Definitions: up = stall[UP_IDX], dn = stall[UP_IDX+1]. UP_IDX+1 < STALL_W is required; this is checked at elaboration.
- All outputs are registered on the rising edge of clk. Combinational path from inputs to outputs: none.
- Reset (rst=0, asynchronous, takes effect immediately even mid-stall):
  - out_valid=0, out_data=NOP_VAL, ctx_o=0, stall_cnt=0, err_stall=0.
- Per-edge priority, highest first:
  1. flush=1: out_valid<=0, out_data<=NOP_VAL, ctx_o<=0, stall_cnt<=0. The flush also discards any in-flight context. err_stall is unchanged.
  2. up=1, dn=0 (bubble): out_valid<=0, out_data<=NOP_VAL, ctx_o<=ctx_i, stall_cnt<=sat_inc(stall_cnt).
  3. up=0, dn=0 (advance): out_valid<=in_valid, ctx_o<=0, stall_cnt<=0. out_data is loaded as follows:
     - in_data when in_valid=1;
     - in_data when GATE_INVALID=0;
     - NOP_VAL otherwise.
  4. up=1, dn=1 (hold): out_valid and out_data keep their values, ctx_o<=ctx_i, stall_cnt<=sat_inc(stall_cnt).
  5. up=0, dn=1 (illegal): treated as hold, so the held payload is not overwritten. ctx_o<=0, stall_cnt<=0, err_stall<=1.
- err_stall stays at 1 until rst.
- sat_inc(x) = x+1 when x < 2^CNT_W-1, else x. There is no wrap-around.
- ctx_o is only non-zero in the cycle after a stalled edge. The producing stage must treat ctx_o as valid only while it is stalled.
- Flush during a multicycle operation: the context is cleared, and the next advance restarts with ctx_o=0.
- Latency: one cycle from an in_data edge to out_data. Throughput: one entry per cycle when not stalled.
- Expected size: 120-250 lines RTL.

Test Plan:
- Reset mid-hold: drive up=dn=1 for 3 cycles, then rst=0 asynchronously between edges.
  - Outputs go to out_valid=0, out_data=NOP_VAL, stall_cnt=0 before the next edge.
- Advance stream: stall=6'b000000, in_valid=1, in_data=1,2,3.
  - out_data=1,2,3 on the following edges with out_valid=1.
  - in_valid=0 with GATE_INVALID=1 gives out_data=NOP_VAL, out_valid=0.
- Multicycle bubble: stall=6'b001111 (up=1, dn=0) for 2 edges, ctx_i=66'h1_0000_0000_0000_0005.
  - out_valid=0, ctx_o equals ctx_i each cycle, stall_cnt=1 then 2.
  - On release: ctx_o=0, stall_cnt=0, payload advances.
- Saturation: up=dn=1 for 20 edges with CNT_W=4.
  - stall_cnt stops at 15; out_data held unchanged throughout.
- Flush priority: flush=1 with stall=6'b001111 and in_valid=1.
  - out_valid=0, out_data=NOP_VAL, ctx_o=0, stall_cnt=0.
- Illegal stall: stall=6'b010000 (up=0, dn=1), with out_data=0xAA and in_data=0xBB.
  - out_data remains 0xAA, err_stall=1 and stays 1 after stall returns to 0, until rst.
